// File: rtl/line_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : line_mem_responder
//  Description : Cache-line physical-memory responder for the L2 line bus.
//                Accepts one read or write line request at a time, serves it
//                from an internal line array after LATENCY busy cycles and
//                pulses pmem_resp for a single cycle on completion.
//                Optional protocol checker enabled by LINEMEM_PROTO_CHK_EN,
//                which adds the sticky proto_err output.
//  Revision    : 1.0  initial release
// ============================================================================
module line_mem_responder #(
   parameter int ADDR_W  = 16,
   parameter int LINE_W  = 128,
   parameter int OFF_W   = 4,
   parameter int IDX_W   = 6,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pmem_address,
   input  logic [LINE_W-1:0] pmem_wdata,
   input  logic              pmem_read,
   input  logic              pmem_write,
   output logic [LINE_W-1:0] pmem_rdata,
   output logic              pmem_resp,
   output logic              busy
`ifdef LINEMEM_PROTO_CHK_EN
  ,output logic              proto_err
`endif
);

   // LATENCY is limited to 1..255, so LATENCY-1 always fits in 8 bits.
   localparam int c_CNT_W = 8;
   localparam int c_DEPTH = 2 ** IDX_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [IDX_W-1:0]     r_idx;
   logic                 r_is_write;
   logic [LINE_W-1:0]    r_wdata;
   logic [LINE_W-1:0]    r_rdata;
   logic [LINE_W-1:0]    r_mem [c_DEPTH];

   logic                 w_req;
   logic                 w_start;
   logic                 w_commit;
   logic [IDX_W-1:0]     w_idx;

   // Offset bits and the aliased upper address bits play no part in indexing.
   logic                 w_unused_addr;

   assign w_req         = pmem_read | pmem_write;
   assign w_idx         = pmem_address[OFF_W+IDX_W-1:OFF_W];
   assign w_unused_addr = ^{pmem_address[ADDR_W-1:OFF_W+IDX_W], pmem_address[OFF_W-1:0]};

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode plus the start and commit strobes.
   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               w_start      = 1'b1;
               w_state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (r_cnt == '0) begin
               w_commit     = 1'b1;
               w_state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Latch the request on start and count down the busy interval.
   // A simultaneous read and write is latched as a write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_idx      <= '0;
         r_is_write <= 1'b0;
         r_wdata    <= '0;
      end else if (w_start) begin
         r_cnt      <= c_CNT_W'(LATENCY - 1);
         r_idx      <= w_idx;
         r_is_write <= pmem_write;
         r_wdata    <= pmem_wdata;
      end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
         r_cnt      <= r_cnt - 1'b1;
      end
   end

   // Line array write port; no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (w_commit && r_is_write) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

   // Read data register; only a read commit updates it, then it holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (w_commit && !r_is_write) begin
         r_rdata <= r_mem[r_idx];
      end
   end

   assign pmem_rdata = r_rdata;
   assign pmem_resp  = (r_state == ST_RESP);
   assign busy       = (r_state != ST_IDLE);

`ifdef LINEMEM_PROTO_CHK_EN
   logic r_proto_err;
   logic w_req_held;

   // The request bit that started the transaction must stay high while busy.
   assign w_req_held = r_is_write ? pmem_write : pmem_read;

   // Sticky error: both request bits seen in IDLE, or request dropped in BUSY.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_proto_err <= 1'b0;
      end else if (((r_state == ST_IDLE) && pmem_read && pmem_write) ||
                   ((r_state == ST_BUSY) && !w_req_held)) begin
         r_proto_err <= 1'b1;
      end
   end

   assign proto_err = r_proto_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_mem_responder
//  Description : Self-checking bench for line_mem_responder. Directed vector
//                table, hand-written reset/drop sequences and randomized
//                traffic checked against a line-array reference model.
//                Define LINEMEM_PROTO_CHK_EN to also check proto_err.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_line_mem_responder;

   localparam int c_LAT = 4;

   logic          clk;
   logic          rst;
   logic [15:0]   pmem_address;
   logic [127:0]  pmem_wdata;
   logic          pmem_read;
   logic          pmem_write;
   logic [127:0]  pmem_rdata;
   logic          pmem_resp;
   logic          busy;
`ifdef LINEMEM_PROTO_CHK_EN
   logic          proto_err;
`endif

   line_mem_responder #(
      .ADDR_W  (16),
      .LINE_W  (128),
      .OFF_W   (4),
      .IDX_W   (6),
      .LATENCY (c_LAT)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .busy         (busy)
`ifdef LINEMEM_PROTO_CHK_EN
     ,.proto_err    (proto_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the line array, the last read line and the error flag.
   logic [127:0] mdl_mem [64];
   logic [127:0] mdl_rdata;
   logic         mdl_perr;

   typedef struct packed {
      logic         rd;
      logic         wr;
      logic [15:0]  addr;
      logic [127:0] wdata;
      logic [127:0] exp_rdata;
      logic         exp_perr;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction: request in cycle 0, held until the response
   // (unless dropped at drop_at), then one idle cycle.
   task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [127:0] wd, input int drop_at);
      int idx;
      idx = (int'(addr) / 16) % 64;
      if (wr) begin
         mdl_mem[idx] = wd;
      end else if (rd) begin
         mdl_rdata = mdl_mem[idx];
      end
      if (rd && wr) mdl_perr = 1'b1;
      if (drop_at >= 1 && drop_at <= c_LAT) mdl_perr = 1'b1;

      pmem_read    = rd;
      pmem_write   = wr;
      pmem_address = addr;
      pmem_wdata   = wd;
      for (int c = 1; c <= c_LAT + 1; c++) begin
         tick();
         check("busy_in_txn", {127'd0, busy}, 128'd1);
         check("resp_timing", {127'd0, pmem_resp}, (c == c_LAT + 1) ? 128'd1 : 128'd0);
         if (c == c_LAT + 1) check("rdata_at_resp", pmem_rdata, mdl_rdata);
         if (c == drop_at) begin
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
         end
         // Address and data wander while busy; the latched values must win.
         pmem_address = 16'($urandom);
         pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      tick();
      check("busy_idle", {127'd0, busy}, 128'd0);
      check("resp_idle", {127'd0, pmem_resp}, 128'd0);
      check("rdata_held", pmem_rdata, mdl_rdata);
`ifdef LINEMEM_PROTO_CHK_EN
      check("proto_err", {127'd0, proto_err}, {127'd0, mdl_perr});
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] a5;
      int           sel;
      int           drop;
      logic         rd;
      logic         wr;

      a5 = {16{8'hA5}};
      vecs[0] = '{rd: 1'b0, wr: 1'b1, addr: 16'h0040, wdata: a5,     exp_rdata: 128'd0, exp_perr: 1'b0};
      vecs[1] = '{rd: 1'b1, wr: 1'b0, addr: 16'h0040, wdata: 128'd0, exp_rdata: a5,     exp_perr: 1'b0};
      vecs[2] = '{rd: 1'b1, wr: 1'b1, addr: 16'h0080, wdata: 128'd1, exp_rdata: a5,     exp_perr: 1'b1};
      vecs[3] = '{rd: 1'b1, wr: 1'b0, addr: 16'h0080, wdata: 128'd0, exp_rdata: 128'd1, exp_perr: 1'b1};
      vecs[4] = '{rd: 1'b0, wr: 1'b1, addr: 16'h0400, wdata: 128'd7, exp_rdata: 128'd1, exp_perr: 1'b1};
      vecs[5] = '{rd: 1'b1, wr: 1'b0, addr: 16'h0000, wdata: 128'd0, exp_rdata: 128'd7, exp_perr: 1'b1};

      for (int i = 0; i < 64; i++) mdl_mem[i] = '0;
      mdl_rdata    = '0;
      mdl_perr     = 1'b0;
      rst          = 1'b1;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;

      // Reset state.
      tick();
      tick();
      check("rst_resp",  {127'd0, pmem_resp}, 128'd0);
      check("rst_busy",  {127'd0, busy}, 128'd0);
      check("rst_rdata", pmem_rdata, 128'd0);
`ifdef LINEMEM_PROTO_CHK_EN
      check("rst_proto_err", {127'd0, proto_err}, 128'd0);
`endif
      rst = 1'b0;
      tick();

      // Put every line into a known all-zero state.
      for (int i = 0; i < 64; i++) run_txn(1'b0, 1'b1, 16'(i * 16), 128'd0, -1);

      // Directed vector table.
      for (int i = 0; i < 6; i++) begin
         run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, -1);
         check("vec_rdata", pmem_rdata, vecs[i].exp_rdata);
`ifdef LINEMEM_PROTO_CHK_EN
         check("vec_proto_err", {127'd0, proto_err}, {127'd0, vecs[i].exp_perr});
`endif
      end

      // Reset during BUSY abandons the write.
      pmem_write   = 1'b1;
      pmem_address = 16'h0010;
      pmem_wdata   = {128{1'b1}};
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("abort_busy", {127'd0, busy}, 128'd0);
      check("abort_resp", {127'd0, pmem_resp}, 128'd0);
      check("abort_rdata", pmem_rdata, 128'd0);
      pmem_write = 1'b0;
      tick();
      rst       = 1'b0;
      mdl_rdata = '0;
      mdl_perr  = 1'b0;
      for (int c = 0; c < c_LAT + 2; c++) begin
         tick();
         check("abort_no_resp", {127'd0, pmem_resp}, 128'd0);
      end
      run_txn(1'b1, 1'b0, 16'h0010, 128'd0, -1);
      check("abort_not_committed", pmem_rdata, 128'd0);

      // Read request dropped in cycle 2 still completes.
      run_txn(1'b1, 1'b0, 16'h0040, 128'd0, 2);
      check("drop_rdata", pmem_rdata, a5);

      // Randomized traffic against the model.
      for (int n = 0; n < 60; n++) begin
         sel = int'($urandom_range(0, 9));
         rd  = (sel == 0) || (sel >= 5);
         wr  = (sel <= 4);
         drop = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, c_LAT)) : -1;
         run_txn(rd, wr, 16'($urandom), {$urandom, $urandom, $urandom, $urandom}, drop);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
